// File: rtl/perceptron_trainer_pkg.sv
// Signed fixed-point type, constants and saturating adder shared by the trainer.
// Latency: combinational helpers only.
// Backpressure: none.
package FixedPoint;

    localparam int SFP_W    = 16;
    localparam int SFP_FRAC = 8;

    // Q8.8 signed fixed point
    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp ONE     = sfp'(2 ** SFP_FRAC);
    localparam sfp SFP_MAX = {1'b0, {(SFP_W-1){1'b1}}};
    localparam sfp SFP_MIN = {1'b1, {(SFP_W-1){1'b0}}};

    // Overflow is only possible when both operands share a sign; clamp toward that sign.
    function automatic sfp sfp_sat_add(input sfp a, input sfp b);
        sfp s;
        s = a + b;
        if ((a[SFP_W-1] == b[SFP_W-1]) && (s[SFP_W-1] != a[SFP_W-1]))
            return a[SFP_W-1] ? SFP_MIN : SFP_MAX;
        return s;
    endfunction

endpackage

// File: rtl/perceptron_trainer_core.sv
// Perceptron weights/bias, saturating score chain, step function and update rule.
// Latency: score/pred combinational from x; weight update lands on the next edge.
// Backpressure: none; updates only when update_en is high.
module perceptron_core
    import FixedPoint::*;
#(
    parameter int INPUT_UNITS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   update_en,
    input  logic [INPUT_UNITS-1:0] x,
    input  logic                   target_bit,
    input  sfp                     lr,
    output sfp                     score,
    output logic                   pred,
    output logic                   err_nz
);

    sfp   w [INPUT_UNITS];
    sfp   b;
    sfp   neg_lr;
    sfp   step;
    logic err_pos;

    // Score is accumulated as a chain starting at the bias, saturating after every term.
    always_comb begin
        score = b;
        for (int i = 0; i < INPUT_UNITS; i++) begin
            if (x[i])
                score = sfp_sat_add(score, w[i]);
        end
    end

    assign pred    = (score > sfp'(0));
    assign err_nz  = (target_bit != pred);
    assign err_pos = target_bit & ~pred;
    // -SFP_MIN is not representable, so clamp the negated step to SFP_MAX
    assign neg_lr  = (lr == SFP_MIN) ? SFP_MAX : sfp'(-lr);
    assign step    = err_pos ? lr : neg_lr;

    // Perceptron update: move bias and active weights by +/-lr on a misprediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b <= '0;
            for (int i = 0; i < INPUT_UNITS; i++) w[i] <= '0;
        end else if (clear) begin
            b <= '0;
            for (int i = 0; i < INPUT_UNITS; i++) w[i] <= '0;
        end else if (update_en && err_nz) begin
            b <= sfp_sat_add(b, step);
            for (int i = 0; i < INPUT_UNITS; i++) begin
                if (x[i])
                    w[i] <= sfp_sat_add(w[i], step);
            end
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Trains a perceptron on a full truth table, then scores live switch inputs (macro PERCEPTRON_TRAINER_EARLY_STOP_EN enables early stop).
// Latency: one pattern per cycle while training; inference outputs registered one cycle after sample_in.
// Backpressure: none; start is ignored while training.
module perceptron_trainer
    import FixedPoint::*;
#(
    parameter int INPUT_UNITS = 2,
    parameter int MAX_EPOCHS  = 10
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [2**INPUT_UNITS-1:0]          target,
    input  sfp                                 learning_rate,
    input  logic [INPUT_UNITS-1:0]             sample_in,
    output logic                               busy,
    output logic                               done,
    output logic                               converged,
    output logic [$clog2(MAX_EPOCHS+1)-1:0]    epochs_used,
    output logic                               predict_out,
    output sfp                                 score_out
);

    localparam int NPAT = 2 ** INPUT_UNITS;
    localparam int EW   = $clog2(MAX_EPOCHS + 1);
    localparam logic [EW-1:0] EPOCH_LIMIT = EW'(MAX_EPOCHS);

    typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_INFER} trainer_state_e;

    trainer_state_e           state;
    logic [NPAT-1:0]          target_q;
    sfp                       lr_q;
    logic [INPUT_UNITS-1:0]   p;
    logic [INPUT_UNITS:0]     err_cnt;

    logic                     train_active;
    logic                     accept;
    logic [INPUT_UNITS-1:0]   x;
    logic                     pred;
    logic                     err_nz;
    sfp                       score;
    logic                     last_pat;
    logic                     epoch_clean;
    logic [EW-1:0]            epochs_next;
    logic                     limit_hit;
    logic                     finish_train;

    assign train_active = (state == S_TRAIN);
    assign accept       = start && !train_active;
    assign x            = train_active ? p : sample_in;
    assign last_pat     = (p == '1);
    // the last pattern's own error counts toward this epoch
    assign epoch_clean  = (err_cnt == '0) && !err_nz;
    assign epochs_next  = epochs_used + 1'b1;
    assign limit_hit    = (epochs_next == EPOCH_LIMIT);

`ifdef PERCEPTRON_TRAINER_EARLY_STOP_EN
    assign finish_train = last_pat && (epoch_clean || limit_hit);
`else
    assign finish_train = last_pat && limit_hit;
`endif

    perceptron_core #(.INPUT_UNITS(INPUT_UNITS)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept),
        .update_en  (train_active),
        .x          (x),
        .target_bit (target_q[p]),
        .lr         (lr_q),
        .score      (score),
        .pred       (pred),
        .err_nz     (err_nz)
    );

    // Control FSM: start latching, pattern/epoch/error counters, sticky flags and inference registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            target_q    <= '0;
            lr_q        <= '0;
            p           <= '0;
            err_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            epochs_used <= '0;
            predict_out <= 1'b0;
            score_out   <= '0;
        end else begin
            predict_out <= 1'b0;
            score_out   <= '0;
            case (state)
                S_IDLE, S_INFER: begin
                    if (start) begin
                        state       <= S_TRAIN;
                        target_q    <= target;
                        lr_q        <= learning_rate;
                        p           <= '0;
                        err_cnt     <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        converged   <= 1'b0;
                        epochs_used <= '0;
                    end else if (state == S_INFER) begin
                        predict_out <= pred;
                        score_out   <= score;
                    end
                end
                S_TRAIN: begin
                    if (last_pat) begin
                        epochs_used <= epochs_next;
                        if (finish_train) begin
                            state     <= S_INFER;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            converged <= epoch_clean;
                        end else begin
                            p       <= '0;
                            err_cnt <= '0;
                        end
                    end else begin
                        p <= p + 1'b1;
                        if (err_nz)
                            err_cnt <= err_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: directed training runs and inference probes.
// Expected results are hand-derived traces of the perceptron rule with INPUT_UNITS=2, MAX_EPOCHS=10.
// Outputs are sampled on the falling clock edge.
module tb_perceptron_trainer;
    import FixedPoint::*;

`ifdef PERCEPTRON_TRAINER_EARLY_STOP_EN
    localparam int AND_EP = 6;
    localparam int SAT_EP = 4;
`else
    localparam int AND_EP = 10;
    localparam int SAT_EP = 10;
`endif
    localparam int XOR_EP = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] target = '0;
    sfp         learning_rate = '0;
    logic [1:0] sample_in = '0;
    logic       busy, done, converged, predict_out;
    logic [3:0] epochs_used;
    sfp         score_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    perceptron_trainer #(.INPUT_UNITS(2), .MAX_EPOCHS(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .target        (target),
        .learning_rate (learning_rate),
        .sample_in     (sample_in),
        .busy          (busy),
        .done          (done),
        .converged     (converged),
        .epochs_used   (epochs_used),
        .predict_out   (predict_out),
        .score_out     (score_out)
    );

    typedef struct { string name; int epochs; logic conv; int cycles; } train_exp_t;
    typedef struct { string name; sfp score; logic pred; } infer_exp_t;

    train_exp_t train_q[$];
    infer_exp_t infer_q[$];

    logic probe = 1'b0;
    logic probe_q = 1'b0;
    logic done_prev = 1'b0;
    logic busy_prev = 1'b0;
    int   busy_cyc = 0;

    always @(posedge clk) probe_q <= probe;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: pops expectations when training completes or an inference probe lands
    initial begin : monitor
        train_exp_t te;
        infer_exp_t ie;
        forever begin
            @(negedge clk);
            if (busy && !busy_prev) busy_cyc = 0;
            if (busy) busy_cyc++;
            if (done && !done_prev) begin
                if (train_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: done rose with no expected training result");
                end else begin
                    te = train_q.pop_front();
                    check({te.name, "_epochs"}, epochs_used, te.epochs);
                    check({te.name, "_converged"}, converged, te.conv);
                    check({te.name, "_cycles"}, busy_cyc, te.cycles);
                    check({te.name, "_busy_low"}, busy, 0);
                end
            end
            if (probe_q) begin
                if (infer_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_probe: inference probe with no expectation");
                end else begin
                    ie = infer_q.pop_front();
                    check({ie.name, "_score"}, score_out, ie.score);
                    check({ie.name, "_pred"}, predict_out, ie.pred);
                end
            end
            done_prev = done;
            busy_prev = busy;
        end
    end

    task automatic expect_train(input string name, input int ep, input logic conv);
        train_exp_t e;
        e.name = name; e.epochs = ep; e.conv = conv; e.cycles = ep * 4;
        train_q.push_back(e);
    endtask

    task automatic pulse_start(input logic [3:0] t, input sfp lr);
        @(negedge clk);
        target = t; learning_rate = lr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, n);
        end
        @(negedge clk);
    endtask

    task automatic infer(input string name, input logic [1:0] s, input sfp sc, input logic pr);
        infer_exp_t e;
        @(negedge clk);
        sample_in = s;
        e.name = name; e.score = sc; e.pred = pr;
        infer_q.push_back(e);
        probe = 1'b1;
        @(negedge clk);
        probe = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_converged"}, converged, 0);
        check({name, "_epochs"}, epochs_used, 0);
        check({name, "_predict"}, predict_out, 0);
        check({name, "_score"}, score_out, 0);
    endtask

    task automatic and_inference(input string name);
        infer({name, "_11"}, 2'b11, ONE, 1'b1);
        infer({name, "_01"}, 2'b01, -ONE, 1'b0);
        infer({name, "_00"}, 2'b00, -(ONE * 2), 1'b0);
        infer({name, "_10"}, 2'b10, '0, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        sample_in = 2'b11;
        repeat (3) @(negedge clk);
        check("idle_predict", predict_out, 0);
        check("idle_score", score_out, 0);

        // AND: w=(ONE, 2*ONE), b=-2*ONE once trained
        expect_train("and", AND_EP, 1'b1);
        pulse_start(4'b1000, ONE);
        check("and_busy_started", busy, 1);
        wait_done("and");
        and_inference("and");
        check("and_sticky_epochs", epochs_used, AND_EP);
        check("and_sticky_done", done, 1);

        // XOR never separates: full epoch budget, not converged
        expect_train("xor", XOR_EP, 1'b0);
        pulse_start(4'b0110, ONE);
        check("xor_done_cleared", done, 0);
        wait_done("xor");

        // reset in the fifth TRAIN cycle, then retrain AND from scratch
        pulse_start(4'b1000, ONE);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", busy, 0);
        expect_train("and2", AND_EP, 1'b1);
        pulse_start(4'b1000, ONE);
        wait_done("and2");
        and_inference("and2");

        // saturation: lr=SFP_MAX; a start pulse mid-training must be ignored
        expect_train("sat", SAT_EP, 1'b1);
        pulse_start(4'b0001, SFP_MAX);
        repeat (2) @(negedge clk);
        pulse_start(4'b1111, ONE);
        wait_done("sat");
        infer("sat_00", 2'b00, SFP_MAX, 1'b1);
        infer("sat_01", 2'b01, '0, 1'b0);
        infer("sat_10", 2'b10, '0, 1'b0);
        infer("sat_11", 2'b11, -SFP_MAX, 1'b0);

        repeat (2) @(negedge clk);
        check("train_q_drained", train_q.size(), 0);
        check("infer_q_drained", infer_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
